mda_adc_scan_ctrl: RTL and testbench

MDA_ADC_SCAN_CTRL -- requirements
Module: mda_adc_scan_ctrl

---
 rtl/mda_adc_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_mda_adc_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mda_adc_scan_ctrl.sv
// ADC scan sequencer: walks the enabled channels in ascending order, one
// conversion request at a time, and stores each result in a per-channel
// result register. Scans start from a periodic tick or a software pulse.
// A trigger that arrives while a scan is running is dropped and flagged
// as overrun.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a trigger; conv_req low
// REQ   | conv_req high on cur_ch, waiting for conv_ack
// GAP   | one-cycle spacer after an ack; selects next channel or ends
module mda_adc_scan_ctrl #(
    parameter int NUM_CH   = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                slave_clk,
    input  logic                slave_reset,
    input  logic                cfg_enable,
    input  logic [NUM_CH-1:0]   cfg_ch_mask,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                scan_start,
    input  logic                clr_overrun,
    output logic                conv_req,
    output logic [2:0]          conv_ch,
    input  logic                conv_ack,
    input  logic [11:0]         conv_data,
    input  logic [2:0]          res_addr,
    output logic [11:0]         res_data,
    output logic [NUM_CH-1:0]   res_valid,
    output logic                busy,
    output logic                scan_done,
    output logic                overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [NUM_CH-1:0]   scan_mask_q;
    logic [2:0]          cur_ch_q;
    logic                conv_req_q;
    logic                busy_q;
    logic                scan_done_q;
    logic                overrun_q;
    logic [NUM_CH-1:0]   res_valid_q;
    logic [11:0]         res_q [NUM_CH];

    logic                period_run;
    logic                tick;
    logic                trigger;
    logic [NUM_CH-1:0]   above_mask;

    // Index of the lowest set bit; callers only use it on a non-zero mask.
    function automatic logic [2:0] lowest_bit(input logic [NUM_CH-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign period_run = cfg_enable && (cfg_period != '0);
    assign tick       = period_run && (cnt_q == '0);
    assign trigger    = tick || scan_start;

    // Channels of the latched mask strictly above cur_ch; empty once cur_ch is 7,
    // so the scan can never wrap back to channel 0.
    assign above_mask = scan_mask_q & (({NUM_CH{1'b1}} << cur_ch_q) << 1);

    // Period down-counter: reloads on terminal count, parked at period-1 when idle.
    always_ff @(posedge slave_clk) begin
        if (slave_reset) begin
            cnt_q <= cfg_period - PERIOD_W'(1);
        end else if (!period_run || (cnt_q == '0)) begin
            cnt_q <= cfg_period - PERIOD_W'(1);
        end else begin
            cnt_q <= cnt_q - PERIOD_W'(1);
        end
    end

    // Scan FSM with registered request, status flags and result storage.
    always_ff @(posedge slave_clk) begin
        if (slave_reset) begin
            state_q     <= S_IDLE;
            scan_mask_q <= '0;
            cur_ch_q    <= '0;
            conv_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            res_valid_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            scan_done_q <= 1'b0;

            // Setting wins over clearing so a dropped trigger is never lost.
            if (trigger && busy_q) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (trigger && (cfg_ch_mask != '0)) begin
                        scan_mask_q <= cfg_ch_mask;
                        cur_ch_q    <= lowest_bit(cfg_ch_mask);
                        conv_req_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (conv_ack) begin
                        res_q[cur_ch_q]       <= conv_data;
                        res_valid_q[cur_ch_q] <= 1'b1;
                        conv_req_q            <= 1'b0;
                        // Decided one cycle early so the pulse lands on the GAP->IDLE cycle.
                        scan_done_q           <= (above_mask == '0);
                        state_q               <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (above_mask != '0) begin
                        cur_ch_q   <= lowest_bit(above_mask);
                        conv_req_q <= 1'b1;
                        state_q    <= S_REQ;
                    end else begin
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    conv_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign conv_req  = conv_req_q;
    assign conv_ch   = cur_ch_q;
    assign busy      = busy_q;
    assign scan_done = scan_done_q;
    assign overrun   = overrun_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_q[res_addr];

endmodule

// File: tb/tb_mda_adc_scan_ctrl.sv
// Directed bench for the ADC scan sequencer: a table of single-scan
// records plus hand-written periodic, overrun and reset sequences.
module tb_mda_adc_scan_ctrl;

    logic        slave_clk = 1'b0;
    logic        slave_reset;
    logic        cfg_enable;
    logic [7:0]  cfg_ch_mask;
    logic [15:0] cfg_period;
    logic        scan_start;
    logic        clr_overrun;
    logic        conv_req;
    logic [2:0]  conv_ch;
    logic        conv_ack;
    logic [11:0] conv_data;
    logic [2:0]  res_addr;
    logic [11:0] res_data;
    logic [7:0]  res_valid;
    logic        busy;
    logic        scan_done;
    logic        overrun;

    int checks   = 0;
    int failures = 0;
    int sd_cnt   = 0;

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  chg_mask;
        int          dly;
        logic [11:0] data0;
        logic [11:0] dstep;
        int          exp_n;
        logic [2:0]  exp_first;
        logic [2:0]  exp_last;
        logic [11:0] exp_last_data;
        logic [7:0]  exp_valid;
    } scan_rec_t;

    scan_rec_t tbl [6];

    int   rise_cnt;
    int   rise_at [4];
    logic prev_req;
    int   age;
    logic any_busy;
    logic any_req;

    always #5 slave_clk = ~slave_clk;

    mda_adc_scan_ctrl #(
        .NUM_CH   (8),
        .PERIOD_W (16)
    ) dut (
        .slave_clk   (slave_clk),
        .slave_reset (slave_reset),
        .cfg_enable  (cfg_enable),
        .cfg_ch_mask (cfg_ch_mask),
        .cfg_period  (cfg_period),
        .scan_start  (scan_start),
        .clr_overrun (clr_overrun),
        .conv_req    (conv_req),
        .conv_ch     (conv_ch),
        .conv_ack    (conv_ack),
        .conv_data   (conv_data),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .busy        (busy),
        .scan_done   (scan_done),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge slave_clk);
        #1;
        if (scan_done === 1'b1) sd_cnt++;
    endtask

    task automatic do_reset();
        slave_reset = 1'b1;
        step();
        step();
        slave_reset = 1'b0;
        sd_cnt = 0;
    endtask

    task automatic run_scan(input scan_rec_t t);
        int          n;
        int          guard;
        logic        fin;
        logic [2:0]  prev;
        logic [2:0]  first;
        logic [2:0]  last;
        logic [11:0] d;
        n = 0; guard = 0; fin = 1'b0; prev = '0; first = '0; last = '0;
        cfg_enable  = 1'b0;
        cfg_period  = '0;
        cfg_ch_mask = t.mask;
        do_reset();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        chk("start_latency", conv_req, 1);
        while (!fin && guard < 500) begin
            guard++;
            if (conv_req) begin
                if (n == 0) first = conv_ch;
                else chk("ascending", conv_ch > prev, 1);
                chk("ch_in_mask", t.mask[conv_ch], 1);
                prev = conv_ch;
                last = conv_ch;
                for (int k = 0; k < t.dly; k++) begin
                    step();
                    chk("req_hold", conv_req, 1);
                    chk("ch_hold", conv_ch, prev);
                end
                d = t.data0 + 12'(n) * t.dstep;
                conv_ack  = 1'b1;
                conv_data = d;
                step();
                conv_ack  = 1'b0;
                conv_data = '0;
                n++;
                if (n == 1) cfg_ch_mask = t.chg_mask;
                chk("gap_low", conv_req, 0);
                chk("gap_busy", busy, 1);
                chk("done_in_gap", scan_done, (n == t.exp_n) ? 1 : 0);
                step();
                if (!conv_req) begin
                    chk("idle_after", busy, 0);
                    fin = 1'b1;
                end
            end else begin
                chk("req_expected", conv_req, 1);
                fin = 1'b1;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout: scan still running after %0d conversions", n);
        end
        step(); step(); step();
        chk("scan_done_count", sd_cnt, 1);
        chk("n_conv", n, t.exp_n);
        chk("first_ch", first, t.exp_first);
        chk("last_ch", last, t.exp_last);
        chk("res_valid", res_valid, t.exp_valid);
        res_addr = t.exp_first;
        #1;
        chk("res_first", res_data, t.data0);
        res_addr = t.exp_last;
        #1;
        chk("res_last", res_data, t.exp_last_data);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h05, 8'h05, 3, 12'h123, 12'h333, 2, 3'd0, 3'd2, 12'h456, 8'h05};
        tbl[1] = '{8'h80, 8'h80, 0, 12'hABC, 12'h000, 1, 3'd7, 3'd7, 12'hABC, 8'h80};
        tbl[2] = '{8'hFF, 8'hFF, 1, 12'h010, 12'h101, 8, 3'd0, 3'd7, 12'h717, 8'hFF};
        tbl[3] = '{8'h81, 8'h81, 2, 12'h800, 12'h0FF, 2, 3'd0, 3'd7, 12'h8FF, 8'h81};
        tbl[4] = '{8'h18, 8'h18, 5, 12'h001, 12'h002, 2, 3'd3, 3'd4, 12'h003, 8'h18};
        tbl[5] = '{8'h0F, 8'hF0, 1, 12'h200, 12'h010, 4, 3'd0, 3'd3, 12'h230, 8'h0F};

        slave_reset = 1'b0; cfg_enable = 1'b0; cfg_ch_mask = 8'h00; cfg_period = 16'd0;
        scan_start = 1'b0; clr_overrun = 1'b0; conv_ack = 1'b0; conv_data = '0; res_addr = 3'd0;

        // Reset values
        do_reset();
        chk("rst_conv_req", conv_req, 0);
        chk("rst_conv_ch", conv_ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);

        // Ack while idle must not write anything
        conv_ack = 1'b1; conv_data = 12'hFFF;
        step();
        conv_ack = 1'b0; conv_data = '0;
        chk("idle_ack_valid", res_valid, 0);
        res_addr = 3'd3;
        #1;
        chk("idle_ack_data", res_data, 0);

        // Empty mask: trigger ignored
        cfg_ch_mask = 8'h00;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        any_busy = busy; any_req = conv_req;
        for (int c = 0; c < 5; c++) begin
            step();
            any_busy |= busy;
            any_req  |= conv_req;
        end
        chk("mask0_busy", any_busy, 0);
        chk("mask0_req", any_req, 0);
        chk("mask0_done", sd_cnt, 0);

        // Table of single scans
        for (int r = 0; r < 6; r++) run_scan(tbl[r]);

        // Periodic scanning, period 100, immediate ack
        cfg_enable = 1'b1; cfg_period = 16'd100; cfg_ch_mask = 8'h80;
        do_reset();
        rise_cnt = 0; prev_req = 1'b0;
        for (int i = 0; i < 4; i++) rise_at[i] = -1;
        for (int c = 0; c <= 320; c++) begin
            if (conv_req && !prev_req) begin
                if (rise_cnt < 4) rise_at[rise_cnt] = c;
                rise_cnt++;
                chk("periodic_ch", conv_ch, 7);
            end
            prev_req   = conv_req;
            conv_ack   = conv_req;
            conv_data  = 12'h0A0 + 12'(c);
            scan_start = (c == 199);
            step();
        end
        conv_ack = 1'b0; scan_start = 1'b0;
        chk("periodic_rises", rise_cnt, 3);
        chk("periodic_first", rise_at[0], 100);
        chk("periodic_second", rise_at[1], 200);
        chk("periodic_third", rise_at[2], 300);
        chk("periodic_overrun", overrun, 0);
        chk("periodic_done_cnt", sd_cnt, 3);

        // Overrun set, clear, and set-beats-clear
        cfg_enable = 1'b1; cfg_period = 16'd10; cfg_ch_mask = 8'hFF;
        do_reset();
        age = 0;
        for (int c = 0; c <= 45; c++) begin
            if (c == 15) chk("ovr_busy", busy, 1);
            if (c == 15) chk("ovr_before_drop", overrun, 0);
            if (c == 20) chk("ovr_set", overrun, 1);
            if (c == 23) chk("ovr_cleared", overrun, 0);
            if (c == 29) chk("ovr_still_clear", overrun, 0);
            if (c == 30) chk("ovr_set_again", overrun, 1);
            if (c == 33) chk("ovr_cleared2", overrun, 0);
            if (c == 40) chk("ovr_set_wins", overrun, 1);
            age = conv_req ? age + 1 : 0;
            conv_ack    = (age > 20);
            conv_data   = 12'h3C3;
            clr_overrun = (c == 22 || c == 32 || c == 39);
            step();
        end
        conv_ack = 1'b0; clr_overrun = 1'b0; cfg_enable = 1'b0;

        // Reset in REQ on channel 2 with a coincident ack
        cfg_ch_mask = 8'h04; cfg_period = 16'd0;
        do_reset();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        chk("rst_mid_req", conv_req, 1);
        chk("rst_mid_ch", conv_ch, 2);
        step();
        slave_reset = 1'b1; conv_ack = 1'b1; conv_data = 12'h777;
        step();
        slave_reset = 1'b0; conv_ack = 1'b0; conv_data = '0;
        chk("rst_mid_req_low", conv_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", res_valid, 0);
        res_addr = 3'd2;
        #1;
        chk("rst_mid_res2", res_data, 0);
        step(); step(); step();
        chk("rst_mid_no_done", sd_cnt, 0);
        chk("rst_mid_stay_idle", conv_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
